// File: rtl/axi3_ic_pkg.sv
// Shared definitions for the two-master AXI3 write-path crossbar:
// address map, response codes, slave-port FSM states and the address decoder.
// Optional feature macro: AXI3_IC_DECERR_EN (unmapped regions go to an internal
// DECERR slave instead of aliasing on AWADDR[28]).
package axi3_ic_pkg;

   localparam logic [3:0] S0_REGION = 4'h0;
   localparam logic [3:0] S1_REGION = 4'h1;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] DECERR = 2'b11;

   localparam logic [1:0] TGT_S0  = 2'd0;
   localparam logic [1:0] TGT_S1  = 2'd1;
   localparam logic [1:0] TGT_DEF = 2'd2;

   typedef enum logic [1:0] {
      PORT_IDLE = 2'd0,
      PORT_ADDR = 2'd1,
      PORT_DATA = 2'd2,
      PORT_RESP = 2'd3
   } port_state_t;

   // Maps a write address to the index of the slave port that serves it.
   function automatic logic [1:0] decode_target(input logic [31:0] addr);
`ifdef AXI3_IC_DECERR_EN
      if (addr[31:28] == S0_REGION)      decode_target = TGT_S0;
      else if (addr[31:28] == S1_REGION) decode_target = TGT_S1;
      else                               decode_target = TGT_DEF;
`else
      decode_target = addr[28] ? TGT_S1 : TGT_S0;
`endif
   endfunction

endpackage

// File: rtl/axi3_ic_slave_port.sv
// One slave port of the crossbar: round-robin arbiter between the two masters,
// the IDLE/ADDR/DATA/RESP transaction FSM and the master-to-slave muxes.
// Slave-to-master return muxing is done by the top using owner/busy.
module axi3_ic_slave_port
   import axi3_ic_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req,
   input  logic [1:0][31:0] m_awaddr,
   input  logic [1:0][3:0]  m_awlen,
   input  logic [1:0][2:0]  m_awsize,
   input  logic [1:0][1:0]  m_awburst,
   input  logic [1:0]       m_awvalid,
   input  logic [1:0][31:0] m_wdata,
   input  logic [1:0][3:0]  m_wstrb,
   input  logic [1:0]       m_wlast,
   input  logic [1:0]       m_wvalid,
   input  logic [1:0]       m_bready,
   output logic [31:0]      s_awaddr,
   output logic [3:0]       s_awlen,
   output logic [2:0]       s_awsize,
   output logic [1:0]       s_awburst,
   output logic             s_awvalid,
   input  logic             s_awready,
   output logic [31:0]      s_wdata,
   output logic [3:0]       s_wstrb,
   output logic             s_wlast,
   output logic             s_wvalid,
   input  logic             s_wready,
   input  logic [1:0]       s_bresp,
   input  logic             s_bvalid,
   output logic             s_bready,
   output logic             owner,
   output logic             busy,
   output logic             aw_ready,
   output logic             w_ready,
   output logic             b_valid,
   output logic [1:0]       b_resp
);

   port_state_t state;
   logic        winner;

   // Round-robin pick: owner still holds the last grantee after release, so on
   // contention the other master wins; reset value 1 makes M0 win first.
   always_comb begin
      winner = (req == 2'b11) ? ~owner : req[1];
   end

   // Transaction FSM; the grant is registered on leaving IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= PORT_IDLE;
         owner <= 1'b1;
      end else begin
         case (state)
            PORT_IDLE: if (|req) begin
               owner <= winner;
               state <= PORT_ADDR;
            end
            PORT_ADDR: if (m_awvalid[owner] && s_awready) state <= PORT_DATA;
            PORT_DATA: if (m_wvalid[owner] && s_wready && m_wlast[owner]) state <= PORT_RESP;
            PORT_RESP: if (s_bvalid && m_bready[owner]) state <= PORT_IDLE;
            default:   state <= PORT_IDLE;
         endcase
      end
   end

   // Forward the owner's channels only in the phase that uses them; zero otherwise.
   always_comb begin
      busy      = (state != PORT_IDLE);
      s_awaddr  = '0;
      s_awlen   = '0;
      s_awsize  = '0;
      s_awburst = '0;
      s_awvalid = 1'b0;
      s_wdata   = '0;
      s_wstrb   = '0;
      s_wlast   = 1'b0;
      s_wvalid  = 1'b0;
      s_bready  = 1'b0;
      aw_ready  = 1'b0;
      w_ready   = 1'b0;
      b_valid   = 1'b0;
      b_resp    = '0;
      if (busy) begin
         s_awaddr  = m_awaddr[owner];
         s_awlen   = m_awlen[owner];
         s_awsize  = m_awsize[owner];
         s_awburst = m_awburst[owner];
      end
      if (state == PORT_ADDR) begin
         s_awvalid = m_awvalid[owner];
         aw_ready  = s_awready;
      end
      if (state == PORT_DATA) begin
         s_wdata  = m_wdata[owner];
         s_wstrb  = m_wstrb[owner];
         s_wlast  = m_wlast[owner];
         s_wvalid = m_wvalid[owner];
         w_ready  = s_wready;
      end
      if (state == PORT_RESP) begin
         s_bready = m_bready[owner];
         b_valid  = s_bvalid;
         b_resp   = s_bresp;
      end
   end

endmodule

// File: rtl/axi3_interconnect.sv
// Two-master / two-slave AXI3 write-path crossbar (AW, W, B only).
// Each slave has its own port FSM so independent slaves run concurrently.
// Optional feature macro: AXI3_IC_DECERR_EN adds a third port backed by an
// internal default slave that answers every unmapped write with DECERR.
module axi3_interconnect
   import axi3_ic_pkg::*;
(
   input  logic        ACLK,
   input  logic        ARESETn,
   input  logic [31:0] M0_AWADDR,
   input  logic [3:0]  M0_AWLEN,
   input  logic [2:0]  M0_AWSIZE,
   input  logic [1:0]  M0_AWBURST,
   input  logic        M0_AWVALID,
   output logic        M0_AWREADY,
   input  logic [31:0] M0_WDATA,
   input  logic [3:0]  M0_WSTRB,
   input  logic        M0_WLAST,
   input  logic        M0_WVALID,
   output logic        M0_WREADY,
   output logic [1:0]  M0_BRESP,
   output logic        M0_BVALID,
   input  logic        M0_BREADY,
   input  logic [31:0] M1_AWADDR,
   input  logic [3:0]  M1_AWLEN,
   input  logic [2:0]  M1_AWSIZE,
   input  logic [1:0]  M1_AWBURST,
   input  logic        M1_AWVALID,
   output logic        M1_AWREADY,
   input  logic [31:0] M1_WDATA,
   input  logic [3:0]  M1_WSTRB,
   input  logic        M1_WLAST,
   input  logic        M1_WVALID,
   output logic        M1_WREADY,
   output logic [1:0]  M1_BRESP,
   output logic        M1_BVALID,
   input  logic        M1_BREADY,
   output logic [31:0] S0_AWADDR,
   output logic [3:0]  S0_AWLEN,
   output logic [2:0]  S0_AWSIZE,
   output logic [1:0]  S0_AWBURST,
   output logic        S0_AWVALID,
   input  logic        S0_AWREADY,
   output logic [31:0] S0_WDATA,
   output logic [3:0]  S0_WSTRB,
   output logic        S0_WLAST,
   output logic        S0_WVALID,
   input  logic        S0_WREADY,
   input  logic [1:0]  S0_BRESP,
   input  logic        S0_BVALID,
   output logic        S0_BREADY,
   output logic [31:0] S1_AWADDR,
   output logic [3:0]  S1_AWLEN,
   output logic [2:0]  S1_AWSIZE,
   output logic [1:0]  S1_AWBURST,
   output logic        S1_AWVALID,
   input  logic        S1_AWREADY,
   output logic [31:0] S1_WDATA,
   output logic [3:0]  S1_WSTRB,
   output logic        S1_WLAST,
   output logic        S1_WVALID,
   input  logic        S1_WREADY,
   input  logic [1:0]  S1_BRESP,
   input  logic        S1_BVALID,
   output logic        S1_BREADY
);

`ifdef AXI3_IC_DECERR_EN
   localparam int NPORT = 3;
`else
   localparam int NPORT = 2;
`endif

   logic [1:0][31:0] m_awaddr;
   logic [1:0][3:0]  m_awlen;
   logic [1:0][2:0]  m_awsize;
   logic [1:0][1:0]  m_awburst;
   logic [1:0]       m_awvalid;
   logic [1:0][31:0] m_wdata;
   logic [1:0][3:0]  m_wstrb;
   logic [1:0]       m_wlast;
   logic [1:0]       m_wvalid;
   logic [1:0]       m_bready;
   logic [1:0]       m_busy;
   logic [1:0]       m_awready;
   logic [1:0]       m_wready;
   logic [1:0]       m_bvalid;
   logic [1:0][1:0]  m_bresp;

   logic [1:0]  req       [NPORT];
   logic [31:0] s_awaddr  [NPORT];
   logic [3:0]  s_awlen   [NPORT];
   logic [2:0]  s_awsize  [NPORT];
   logic [1:0]  s_awburst [NPORT];
   logic        s_awvalid [NPORT];
   logic        s_awready [NPORT];
   logic [31:0] s_wdata   [NPORT];
   logic [3:0]  s_wstrb   [NPORT];
   logic        s_wlast   [NPORT];
   logic        s_wvalid  [NPORT];
   logic        s_wready  [NPORT];
   logic [1:0]  s_bresp   [NPORT];
   logic        s_bvalid  [NPORT];
   logic        s_bready  [NPORT];
   logic        owner     [NPORT];
   logic        busy      [NPORT];
   logic        aw_ready  [NPORT];
   logic        w_ready   [NPORT];
   logic        b_valid   [NPORT];
   logic [1:0]  b_resp    [NPORT];

   assign m_awaddr  = {M1_AWADDR,  M0_AWADDR};
   assign m_awlen   = {M1_AWLEN,   M0_AWLEN};
   assign m_awsize  = {M1_AWSIZE,  M0_AWSIZE};
   assign m_awburst = {M1_AWBURST, M0_AWBURST};
   assign m_awvalid = {M1_AWVALID, M0_AWVALID};
   assign m_wdata   = {M1_WDATA,   M0_WDATA};
   assign m_wstrb   = {M1_WSTRB,   M0_WSTRB};
   assign m_wlast   = {M1_WLAST,   M0_WLAST};
   assign m_wvalid  = {M1_WVALID,  M0_WVALID};
   assign m_bready  = {M1_BREADY,  M0_BREADY};

   assign s_awready[0] = S0_AWREADY;
   assign s_wready[0]  = S0_WREADY;
   assign s_bresp[0]   = S0_BRESP;
   assign s_bvalid[0]  = S0_BVALID;
   assign s_awready[1] = S1_AWREADY;
   assign s_wready[1]  = S1_WREADY;
   assign s_bresp[1]   = S1_BRESP;
   assign s_bvalid[1]  = S1_BVALID;
`ifdef AXI3_IC_DECERR_EN
   // Default slave: always ready; its response is only visible once the port
   // reaches RESP, so a constant DECERR with BVALID high is sufficient.
   assign s_awready[2] = 1'b1;
   assign s_wready[2]  = 1'b1;
   assign s_bresp[2]   = DECERR;
   assign s_bvalid[2]  = 1'b1;
`endif

   // A master that already owns a port cannot start a second write elsewhere.
   always_comb begin
      m_busy = '0;
      for (int k = 0; k < NPORT; k++) begin
         if (busy[k]) m_busy[owner[k]] = 1'b1;
      end
   end

   // Per-port request vectors from address decode of each master's AWADDR.
   always_comb begin
      for (int k = 0; k < NPORT; k++) begin
         req[k] = '0;
         for (int n = 0; n < 2; n++) begin
            req[k][n] = m_awvalid[n] & ~m_busy[n] & (decode_target(m_awaddr[n]) == 2'(k));
         end
      end
   end

   for (genvar k = 0; k < NPORT; k++) begin : g_port
      axi3_ic_slave_port u_port (
         .clk       (ACLK),
         .rst_n     (ARESETn),
         .req       (req[k]),
         .m_awaddr  (m_awaddr),
         .m_awlen   (m_awlen),
         .m_awsize  (m_awsize),
         .m_awburst (m_awburst),
         .m_awvalid (m_awvalid),
         .m_wdata   (m_wdata),
         .m_wstrb   (m_wstrb),
         .m_wlast   (m_wlast),
         .m_wvalid  (m_wvalid),
         .m_bready  (m_bready),
         .s_awaddr  (s_awaddr[k]),
         .s_awlen   (s_awlen[k]),
         .s_awsize  (s_awsize[k]),
         .s_awburst (s_awburst[k]),
         .s_awvalid (s_awvalid[k]),
         .s_awready (s_awready[k]),
         .s_wdata   (s_wdata[k]),
         .s_wstrb   (s_wstrb[k]),
         .s_wlast   (s_wlast[k]),
         .s_wvalid  (s_wvalid[k]),
         .s_wready  (s_wready[k]),
         .s_bresp   (s_bresp[k]),
         .s_bvalid  (s_bvalid[k]),
         .s_bready  (s_bready[k]),
         .owner     (owner[k]),
         .busy      (busy[k]),
         .aw_ready  (aw_ready[k]),
         .w_ready   (w_ready[k]),
         .b_valid   (b_valid[k]),
         .b_resp    (b_resp[k])
      );
   end

   // Return path: each master sees only the port it currently owns.
   always_comb begin
      m_awready = '0;
      m_wready  = '0;
      m_bvalid  = '0;
      m_bresp   = '0;
      for (int k = 0; k < NPORT; k++) begin
         if (busy[k]) begin
            m_awready[owner[k]] = m_awready[owner[k]] | aw_ready[k];
            m_wready[owner[k]]  = m_wready[owner[k]]  | w_ready[k];
            m_bvalid[owner[k]]  = m_bvalid[owner[k]]  | b_valid[k];
            m_bresp[owner[k]]   = m_bresp[owner[k]]   | b_resp[k];
         end
      end
   end

   assign M0_AWREADY = m_awready[0];
   assign M0_WREADY  = m_wready[0];
   assign M0_BVALID  = m_bvalid[0];
   assign M0_BRESP   = m_bresp[0];
   assign M1_AWREADY = m_awready[1];
   assign M1_WREADY  = m_wready[1];
   assign M1_BVALID  = m_bvalid[1];
   assign M1_BRESP   = m_bresp[1];

   assign S0_AWADDR  = s_awaddr[0];
   assign S0_AWLEN   = s_awlen[0];
   assign S0_AWSIZE  = s_awsize[0];
   assign S0_AWBURST = s_awburst[0];
   assign S0_AWVALID = s_awvalid[0];
   assign S0_WDATA   = s_wdata[0];
   assign S0_WSTRB   = s_wstrb[0];
   assign S0_WLAST   = s_wlast[0];
   assign S0_WVALID  = s_wvalid[0];
   assign S0_BREADY  = s_bready[0];
   assign S1_AWADDR  = s_awaddr[1];
   assign S1_AWLEN   = s_awlen[1];
   assign S1_AWSIZE  = s_awsize[1];
   assign S1_AWBURST = s_awburst[1];
   assign S1_AWVALID = s_awvalid[1];
   assign S1_WDATA   = s_wdata[1];
   assign S1_WSTRB   = s_wstrb[1];
   assign S1_WLAST   = s_wlast[1];
   assign S1_WVALID  = s_wvalid[1];
   assign S1_BREADY  = s_bready[1];

endmodule

// File: tb/tb_axi3_interconnect.sv
// Self-checking bench for axi3_interconnect: scoreboard queues filled when a
// round of writes is issued, monitor pops and compares on every handshake.
// Honours AXI3_IC_DECERR_EN when the design is built with it.
module tb_axi3_interconnect;

   localparam int BUDGET = 300;

   typedef struct {
      int          m;
      logic [31:0] addr;
      logic [3:0]  len;
   } aw_exp_t;

   typedef struct {
      int          m;
      logic [31:0] data;
      logic [3:0]  strb;
      logic        last;
   } w_exp_t;

   logic ACLK = 1'b0;
   logic ARESETn = 1'b0;

   logic [31:0] m_awaddr [2];
   logic [3:0]  m_awlen  [2];
   logic [2:0]  m_awsize [2];
   logic [1:0]  m_awburst[2];
   logic        m_awvalid[2];
   logic        m_awready[2];
   logic [31:0] m_wdata  [2];
   logic [3:0]  m_wstrb  [2];
   logic        m_wlast  [2];
   logic        m_wvalid [2];
   logic        m_wready [2];
   logic [1:0]  m_bresp  [2];
   logic        m_bvalid [2];
   logic        m_bready [2];

   logic [31:0] s_awaddr [2];
   logic [3:0]  s_awlen  [2];
   logic [2:0]  s_awsize [2];
   logic [1:0]  s_awburst[2];
   logic        s_awvalid[2];
   logic        s_awready[2] = '{1'b0, 1'b0};
   logic [31:0] s_wdata  [2];
   logic [3:0]  s_wstrb  [2];
   logic        s_wlast  [2];
   logic        s_wvalid [2];
   logic        s_wready [2] = '{1'b0, 1'b0};
   logic [1:0]  s_bresp  [2] = '{2'b00, 2'b00};
   logic        s_bvalid [2] = '{1'b0, 1'b0};
   logic        s_bready [2];

   aw_exp_t     aw_q [2][$];
   w_exp_t      w_q  [2][$];
   logic [1:0]  b_q  [2][$];

   int          assert_count = 0;
   int          fail_count = 0;
   int          rr_last [3] = '{1, 1, 1};

   bit          r_act  [2];
   logic [31:0] r_addr [2];
   logic [3:0]  r_len  [2];
   logic [31:0] r_data [2][16];
   logic [3:0]  r_strb [2][16];

   logic        slv_wl [2];
   logic        slv_bh [2];

   always #5 ACLK = ~ACLK;

   axi3_interconnect dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .M0_AWADDR(m_awaddr[0]), .M0_AWLEN(m_awlen[0]), .M0_AWSIZE(m_awsize[0]), .M0_AWBURST(m_awburst[0]),
      .M0_AWVALID(m_awvalid[0]), .M0_AWREADY(m_awready[0]),
      .M0_WDATA(m_wdata[0]), .M0_WSTRB(m_wstrb[0]), .M0_WLAST(m_wlast[0]), .M0_WVALID(m_wvalid[0]), .M0_WREADY(m_wready[0]),
      .M0_BRESP(m_bresp[0]), .M0_BVALID(m_bvalid[0]), .M0_BREADY(m_bready[0]),
      .M1_AWADDR(m_awaddr[1]), .M1_AWLEN(m_awlen[1]), .M1_AWSIZE(m_awsize[1]), .M1_AWBURST(m_awburst[1]),
      .M1_AWVALID(m_awvalid[1]), .M1_AWREADY(m_awready[1]),
      .M1_WDATA(m_wdata[1]), .M1_WSTRB(m_wstrb[1]), .M1_WLAST(m_wlast[1]), .M1_WVALID(m_wvalid[1]), .M1_WREADY(m_wready[1]),
      .M1_BRESP(m_bresp[1]), .M1_BVALID(m_bvalid[1]), .M1_BREADY(m_bready[1]),
      .S0_AWADDR(s_awaddr[0]), .S0_AWLEN(s_awlen[0]), .S0_AWSIZE(s_awsize[0]), .S0_AWBURST(s_awburst[0]),
      .S0_AWVALID(s_awvalid[0]), .S0_AWREADY(s_awready[0]),
      .S0_WDATA(s_wdata[0]), .S0_WSTRB(s_wstrb[0]), .S0_WLAST(s_wlast[0]), .S0_WVALID(s_wvalid[0]), .S0_WREADY(s_wready[0]),
      .S0_BRESP(s_bresp[0]), .S0_BVALID(s_bvalid[0]), .S0_BREADY(s_bready[0]),
      .S1_AWADDR(s_awaddr[1]), .S1_AWLEN(s_awlen[1]), .S1_AWSIZE(s_awsize[1]), .S1_AWBURST(s_awburst[1]),
      .S1_AWVALID(s_awvalid[1]), .S1_AWREADY(s_awready[1]),
      .S1_WDATA(s_wdata[1]), .S1_WSTRB(s_wstrb[1]), .S1_WLAST(s_wlast[1]), .S1_WVALID(s_wvalid[1]), .S1_WREADY(s_wready[1]),
      .S1_BRESP(s_bresp[1]), .S1_BVALID(s_bvalid[1]), .S1_BREADY(s_bready[1])
   );

   // One counted comparison; prints a FAIL line on mismatch.
   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assert_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic report_timeout(input string name);
      assert_count++;
      fail_count++;
      $display("[TB] FAIL %s: got no handshake within %0d cycles, expected a handshake", name, BUDGET);
   endtask

   // Address map as described for the crossbar: index 2 is the DECERR sink.
   function automatic int ref_target(input logic [31:0] a);
`ifdef AXI3_IC_DECERR_EN
      if (a[31:28] == 4'h0) return 0;
      if (a[31:28] == 4'h1) return 1;
      return 2;
`else
      return a[28] ? 1 : 0;
`endif
   endfunction

   function automatic bit hs(input int m, input int ch);
      case (ch)
         0:       return m_awvalid[m] && m_awready[m];
         1:       return m_wvalid[m] && m_wready[m];
         default: return m_bvalid[m] && m_bready[m];
      endcase
   endfunction

   // Waits for a handshake on a master channel; sampled mid-cycle, returns after the edge.
   task automatic wait_hs(input int m, input int ch, output bit ok);
      bit done;
      done = 0;
      ok = 0;
      for (int c = 0; c < BUDGET && !done; c++) begin
         @(negedge ACLK);
         done = hs(m, ch);
         @(posedge ACLK);
         #1;
      end
      ok = done;
   endtask

   task automatic master_write(input int m);
      bit ok;
      m_awaddr[m]  = r_addr[m];
      m_awlen[m]   = r_len[m];
      m_awsize[m]  = 3'd2;
      m_awburst[m] = 2'b01;
      m_awvalid[m] = 1'b1;
      wait_hs(m, 0, ok);
      m_awvalid[m] = 1'b0;
      if (!ok) begin
         report_timeout($sformatf("m%0d_aw_handshake", m));
         return;
      end
      for (int b = 0; b <= int'(r_len[m]); b++) begin
         m_wdata[m]  = r_data[m][b];
         m_wstrb[m]  = r_strb[m][b];
         m_wlast[m]  = (b == int'(r_len[m]));
         m_wvalid[m] = 1'b1;
         wait_hs(m, 1, ok);
         m_wvalid[m] = 1'b0;
         m_wlast[m]  = 1'b0;
         if (!ok) begin
            report_timeout($sformatf("m%0d_w_handshake", m));
            return;
         end
      end
      m_bready[m] = 1'b1;
      wait_hs(m, 2, ok);
      m_bready[m] = 1'b0;
      if (!ok) report_timeout($sformatf("m%0d_b_handshake", m));
   endtask

   task automatic push_expect(input int m);
      aw_exp_t a;
      w_exp_t  w;
      int      t;
      t = ref_target(r_addr[m]);
      if (t < 2) begin
         a.m = m; a.addr = r_addr[m]; a.len = r_len[m];
         aw_q[t].push_back(a);
         for (int b = 0; b <= int'(r_len[m]); b++) begin
            w.m = m; w.data = r_data[m][b]; w.strb = r_strb[m][b]; w.last = (b == int'(r_len[m]));
            w_q[t].push_back(w);
         end
      end
      b_q[m].push_back(t == 2 ? 2'b11 : 2'b00);
   endtask

   // Issues one round (both masters start in the same cycle) and predicts grant order.
   task automatic apply_stimulus();
      int t0, t1, first;
      t0 = ref_target(r_addr[0]);
      t1 = ref_target(r_addr[1]);
      if (r_act[0] && r_act[1] && t0 == t1) begin
         first = (rr_last[t0] == 1) ? 0 : 1;
         push_expect(first);
         push_expect(1 - first);
         rr_last[t0] = 1 - first;
      end else begin
         if (r_act[0]) begin push_expect(0); rr_last[t0] = 0; end
         if (r_act[1]) begin push_expect(1); rr_last[t1] = 1; end
      end
      fork
         begin if (r_act[0]) master_write(0); end
         begin if (r_act[1]) master_write(1); end
         begin
            @(negedge ACLK);
            for (int m = 0; m < 2; m++)
               if (r_act[m] && ref_target(r_addr[m]) < 2)
                  check_output($sformatf("m%0d_grant_not_before_edge", m), 32'(s_awvalid[ref_target(r_addr[m])]), 32'd0);
            @(negedge ACLK);
            for (int m = 0; m < 2; m++)
               if (r_act[m] && ref_target(r_addr[m]) < 2)
                  check_output($sformatf("m%0d_grant_one_cycle", m), 32'(s_awvalid[ref_target(r_addr[m])]), 32'd1);
         end
      join
      @(negedge ACLK);
      for (int k = 0; k < 2; k++) begin
         check_output($sformatf("s%0d_idle_awvalid", k), 32'(s_awvalid[k]), 32'd0);
         check_output($sformatf("s%0d_idle_awaddr", k), s_awaddr[k], 32'd0);
         check_output($sformatf("s%0d_idle_bready", k), 32'(s_bready[k]), 32'd0);
      end
      @(posedge ACLK);
      #1;
   endtask

   task automatic set_single(input int m, input logic [31:0] addr, input logic [31:0] data);
      r_act[m] = 1'b1;
      r_addr[m] = addr;
      r_len[m] = 4'd0;
      r_data[m][0] = data;
      r_strb[m][0] = 4'hF;
   endtask

   task automatic check_all_outputs_zero(input string tag);
      for (int k = 0; k < 2; k++) begin
         check_output($sformatf("%s_s%0d_awvalid", tag, k), 32'(s_awvalid[k]), 32'd0);
         check_output($sformatf("%s_s%0d_awaddr", tag, k), s_awaddr[k], 32'd0);
         check_output($sformatf("%s_s%0d_wvalid", tag, k), 32'(s_wvalid[k]), 32'd0);
         check_output($sformatf("%s_s%0d_wdata", tag, k), s_wdata[k], 32'd0);
         check_output($sformatf("%s_s%0d_bready", tag, k), 32'(s_bready[k]), 32'd0);
      end
      for (int m = 0; m < 2; m++) begin
         check_output($sformatf("%s_m%0d_awready", tag, m), 32'(m_awready[m]), 32'd0);
         check_output($sformatf("%s_m%0d_wready", tag, m), 32'(m_wready[m]), 32'd0);
         check_output($sformatf("%s_m%0d_bvalid", tag, m), 32'(m_bvalid[m]), 32'd0);
         check_output($sformatf("%s_m%0d_bresp", tag, m), 32'(m_bresp[m]), 32'd0);
      end
   endtask

   // Behavioural slaves: random AW/W readiness, OKAY response after the last beat.
   always begin
      @(negedge ACLK);
      for (int k = 0; k < 2; k++) begin
         slv_wl[k] = s_wvalid[k] && s_wready[k] && s_wlast[k];
         slv_bh[k] = s_bvalid[k] && s_bready[k];
      end
      @(posedge ACLK);
      #1;
      for (int k = 0; k < 2; k++) begin
         if (!ARESETn) begin
            s_awready[k] = 1'b0;
            s_wready[k]  = 1'b0;
            s_bvalid[k]  = 1'b0;
            s_bresp[k]   = 2'b00;
         end else begin
            s_awready[k] = ($urandom_range(0, 2) != 0);
            s_wready[k]  = ($urandom_range(0, 2) != 0);
            if (slv_bh[k]) s_bvalid[k] = 1'b0;
            if (slv_wl[k]) begin
               s_bvalid[k] = 1'b1;
               s_bresp[k]  = 2'b00;
            end
         end
      end
   end

   // Monitor: pops the scoreboard on every slave AW/W and master B handshake.
   always begin
      aw_exp_t a;
      w_exp_t  w;
      logic [1:0] br;
      @(negedge ACLK);
      if (ARESETn) begin
         for (int k = 0; k < 2; k++) begin
            if (s_awvalid[k] && s_awready[k]) begin
               if (aw_q[k].size() == 0) begin
                  check_output($sformatf("s%0d_unexpected_aw", k), s_awaddr[k], 32'hFFFF_FFFF);
               end else begin
                  a = aw_q[k].pop_front();
                  check_output($sformatf("s%0d_awaddr", k), s_awaddr[k], a.addr);
                  check_output($sformatf("s%0d_awlen", k), 32'(s_awlen[k]), 32'(a.len));
                  check_output($sformatf("s%0d_aw_owner_m%0d_awready", k, a.m), 32'(m_awready[a.m]), 32'd1);
               end
            end
            if (s_wvalid[k] && s_wready[k]) begin
               if (w_q[k].size() == 0) begin
                  check_output($sformatf("s%0d_unexpected_w", k), s_wdata[k], ~s_wdata[k]);
               end else begin
                  w = w_q[k].pop_front();
                  check_output($sformatf("s%0d_wdata", k), s_wdata[k], w.data);
                  check_output($sformatf("s%0d_wstrb", k), 32'(s_wstrb[k]), 32'(w.strb));
                  check_output($sformatf("s%0d_wlast", k), 32'(s_wlast[k]), 32'(w.last));
                  check_output($sformatf("s%0d_w_owner_m%0d_wready", k, w.m), 32'(m_wready[w.m]), 32'd1);
               end
            end
         end
         for (int m = 0; m < 2; m++) begin
            if (m_bvalid[m] && m_bready[m]) begin
               if (b_q[m].size() == 0) begin
                  check_output($sformatf("m%0d_unexpected_b", m), 32'(m_bresp[m]), 32'hFFFF_FFFF);
               end else begin
                  br = b_q[m].pop_front();
                  check_output($sformatf("m%0d_bresp", m), 32'(m_bresp[m]), 32'(br));
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got no end of test, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit ok;
      w_exp_t w;
      aw_exp_t a;
      for (int m = 0; m < 2; m++) begin
         m_awaddr[m] = '0; m_awlen[m] = '0; m_awsize[m] = '0; m_awburst[m] = '0; m_awvalid[m] = 1'b0;
         m_wdata[m] = '0; m_wstrb[m] = '0; m_wlast[m] = 1'b0; m_wvalid[m] = 1'b0; m_bready[m] = 1'b0;
         r_act[m] = 1'b0;
      end
      repeat (3) @(posedge ACLK);
      #1;
      check_all_outputs_zero("reset");
      ARESETn = 1'b1;
      @(posedge ACLK);
      #1;

      $display("[TB] single write M0 -> S0");
      set_single(0, 32'h0000_0000, 32'hDEAD_BEEF);
      apply_stimulus();
      r_act[0] = 1'b0;

      $display("[TB] single write M1 -> S1");
      set_single(1, 32'h1000_0000, 32'hCAFE_1234);
      apply_stimulus();
      r_act[1] = 1'b0;

      $display("[TB] concurrent writes to different slaves");
      set_single(0, 32'h0000_0010, 32'h1234_5678);
      set_single(1, 32'h1000_0010, 32'h8765_4321);
      apply_stimulus();

      $display("[TB] contention on S0, two rounds");
      set_single(0, 32'h0000_0020, 32'hAAAA_BBBB);
      set_single(1, 32'h0000_0030, 32'hCCCC_DDDD);
      apply_stimulus();
      apply_stimulus();
      r_act[0] = 1'b0;
      r_act[1] = 1'b0;

`ifdef AXI3_IC_DECERR_EN
      $display("[TB] unmapped write gets DECERR");
      set_single(0, 32'h2000_0000, 32'h5555_AAAA);
      apply_stimulus();
      r_act[0] = 1'b0;
`endif

      $display("[TB] randomized rounds");
      for (int r = 0; r < 40; r++) begin
         for (int m = 0; m < 2; m++) begin
            r_act[m] = ($urandom_range(0, 3) != 0);
            r_addr[m] = {($urandom_range(0, 5) == 0) ? 4'($urandom_range(2, 15)) : 4'($urandom_range(0, 1)),
                         28'($urandom) & 28'h0FF_FFFC};
            r_len[m] = 4'($urandom_range(0, 3));
            for (int b = 0; b < 16; b++) begin
               r_data[m][b] = $urandom;
               r_strb[m][b] = 4'($urandom_range(1, 15));
            end
         end
         apply_stimulus();
      end

      for (int k = 0; k < 2; k++) begin
         check_output($sformatf("s%0d_aw_queue_drained", k), 32'(aw_q[k].size()), 32'd0);
         check_output($sformatf("s%0d_w_queue_drained", k), 32'(w_q[k].size()), 32'd0);
         check_output($sformatf("m%0d_b_queue_drained", k), 32'(b_q[k].size()), 32'd0);
      end

      $display("[TB] reset during DATA phase");
      a.m = 0; a.addr = 32'h0000_0040; a.len = 4'd3;
      aw_q[0].push_back(a);
      w.m = 0; w.data = 32'h1111_2222; w.strb = 4'hF; w.last = 1'b0;
      w_q[0].push_back(w);
      m_awaddr[0] = 32'h0000_0040;
      m_awlen[0] = 4'd3;
      m_awvalid[0] = 1'b1;
      wait_hs(0, 0, ok);
      m_awvalid[0] = 1'b0;
      if (!ok) report_timeout("rst_m0_aw_handshake");
      m_wdata[0] = 32'h1111_2222;
      m_wstrb[0] = 4'hF;
      m_wlast[0] = 1'b0;
      m_wvalid[0] = 1'b1;
      @(negedge ACLK);
      check_output("rst_s0_wvalid_in_data", 32'(s_wvalid[0]), 32'd1);
      #2;
      ARESETn = 1'b0;
      #1;
      check_all_outputs_zero("midrst");
      m_wvalid[0] = 1'b0;
      aw_q[0].delete();
      w_q[0].delete();

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
